hid_event_queue: RTL and testbench

USB HID report queue and CPU register controller for the RVLeon USB peripheral. It sits between `usb_hid_host` and the CPU bus. Every HID report strobed by the host core is captured into a small FIFO, tagged with its device type. The CPU drains the FIFO through four memory-mapped words, and the block raises a level interrupt while work is pending, so no report is silently overwritten between CPU reads.

---
 rtl/hid_event_queue.sv | 134 +++++++++++++
 tb/tb_hid_event_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hid_event_queue.sv
// hid_event_queue: HID report FIFO with CPU register interface and level interrupt.
// Ports: clk, rst (async, active-high); usb_type/usb_report/hid_report/usb_conerr from
// usb_hid_host; cpu_valid/cpu_rdstrb/cpu_wrstrb/cpu_addr/cpu_wdata -> cpu_rdata/cpu_ready
// bus slave; irq level interrupt.
// Optional macro HID_QUEUE_DEDUP_EN: drop reports identical to the last accepted entry.
module hid_event_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  usb_type,
    input  logic        usb_report,
    input  logic [63:0] hid_report,
    input  logic        usb_conerr,
    input  logic        cpu_valid,
    input  logic        cpu_rdstrb,
    input  logic        cpu_wrstrb,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {B_IDLE, B_ACK} bus_t;

    bus_t              r_state, w_state_nx;
    logic [65:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_cnt;
    logic              r_ovf, r_cerr, r_irq_en, r_conerr_d, r_irq, r_ready;
    logic [31:0]       r_rdata;
    logic              w_access, w_ne, w_full, w_pop, w_ctrl_wr, w_clr, w_flush;
    logic              w_cerr_rise, w_push_req, w_push, w_drop, w_dup;
    logic [65:0]       w_head;
    logic [31:0]       w_status, w_rdata;
    logic              w_unused;

    assign w_unused    = ^cpu_wdata[31:3];
    assign w_access    = (r_state == B_IDLE) & cpu_valid & (cpu_rdstrb | cpu_wrstrb);
    assign w_ne        = r_cnt != '0;
    // count never exceeds DEPTH, a power of two, so its MSB alone means full
    assign w_full      = r_cnt[AW];
    assign w_head      = r_mem[r_rp];
    assign w_pop       = w_access & cpu_rdstrb & (cpu_addr == 2'd2) & w_ne;
    assign w_ctrl_wr   = w_access & cpu_wrstrb & (cpu_addr == 2'd3);
    assign w_clr       = w_ctrl_wr & cpu_wdata[1];
    assign w_cerr_rise = usb_conerr & ~r_conerr_d;
    assign w_flush     = (w_ctrl_wr & cpu_wdata[2]) | w_cerr_rise;
    assign w_push_req  = usb_report & (usb_type != 2'd0) & ~w_dup & ~w_flush;
    // a simultaneous pop frees a slot, so a full queue still accepts the push
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;

`ifdef HID_QUEUE_DEDUP_EN
    logic [65:0] r_last;
    logic        r_last_v;

    assign w_dup = r_last_v & (r_last == {usb_type, hid_report});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= '0;
            r_last_v <= 1'b0;
        end else if (w_flush) begin
            r_last_v <= 1'b0;
        end else if (w_push) begin
            r_last   <= {usb_type, hid_report};
            r_last_v <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_status = {19'b0, 5'(r_cnt), 2'b0, w_ne ? w_head[65:64] : 2'b0,
                       r_cerr, r_ovf, w_full, w_ne};

    always_comb begin
        w_rdata    = cpu_addr == 2'd0 ? w_status :
                     cpu_addr == 2'd1 ? (w_ne ? w_head[31:0] : 32'b0) :
                     cpu_addr == 2'd2 ? (w_ne ? w_head[63:32] : 32'b0) :
                                        {31'b0, r_irq_en};
        w_state_nx = (r_state == B_IDLE && w_access) ? B_ACK : B_IDLE;
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {usb_type, hid_report};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= B_IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_cerr     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_conerr_d <= 1'b0;
            r_irq      <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_conerr_d <= usb_conerr;
            if (w_flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + 1'b1;
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            end
            r_ovf  <= w_drop | (r_ovf & ~w_clr);
            r_cerr <= w_cerr_rise | (r_cerr & ~w_clr);
            if (w_ctrl_wr)
                r_irq_en <= cpu_wdata[0];
            r_irq   <= r_irq_en & (w_ne | r_ovf | r_cerr);
            r_ready <= w_access;
            if (w_access)
                r_rdata <= cpu_rdstrb ? w_rdata : 32'b0;
        end
    end

    assign cpu_rdata = r_rdata;
    assign cpu_ready = r_ready;
    assign irq       = r_irq;
endmodule

// File: tb/tb_hid_event_queue.sv
// tb_hid_event_queue: directed self-checking bench for hid_event_queue (DEPTH = 4).
module tb_hid_event_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  usb_type = '0;
    logic        usb_report = 1'b0;
    logic [63:0] hid_report = '0;
    logic        usb_conerr = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_rdstrb = 1'b0;
    logic        cpu_wrstrb = 1'b0;
    logic [1:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        irq;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] d;

    hid_event_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .usb_type(usb_type), .usb_report(usb_report),
        .hid_report(hid_report), .usb_conerr(usb_conerr), .cpu_valid(cpu_valid),
        .cpu_rdstrb(cpu_rdstrb), .cpu_wrstrb(cpu_wrstrb), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        int k;
        cpu_valid  = 1'b1;
        cpu_rdstrb = ~wr;
        cpu_wrstrb = wr;
        cpu_addr   = a;
        cpu_wdata  = wd;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!cpu_ready && k < 8);
        chk("ready", {31'b0, cpu_ready}, 32'd1);
        chk("latency", k, 32'd1);
        rd = cpu_rdata;
        cpu_valid  = 1'b0;
        cpu_rdstrb = 1'b0;
        cpu_wrstrb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(1'b0, a, 32'b0, v);
        chk(tag, v, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] v);
        logic [31:0] dummy;
        bus(1'b1, a, v, dummy);
    endtask

    task automatic push(input logic [1:0] t, input logic [63:0] r);
        usb_report = 1'b1;
        usb_type   = t;
        hid_report = r;
        @(posedge clk);
        #1;
        usb_report = 1'b0;
        usb_type   = 2'd0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("rst_status", 2'd0, 32'h0000_0000);

        wr(2'd3, 32'h1);
        rd_chk("ctrl_rd", 2'd3, 32'h1);
        push(2'd1, 64'h0000_0004_0000_0002);
        rd_chk("kb_status", 2'd0, 32'h0000_0111);
        chk("kb_irq", {31'b0, irq}, 32'd1);
        rd_chk("kb_lo", 2'd1, 32'h0000_0002);
        rd_chk("kb_lo_nopop", 2'd1, 32'h0000_0002);
        rd_chk("kb_hi", 2'd2, 32'h0000_0004);
        rd_chk("kb_empty", 2'd0, 32'h0000_0000);
        chk("kb_irq_off", {31'b0, irq}, 32'd0);

        for (int i = 0; i < 5; i++)
            push(2'd2, {32'(32'hA0 + i), 32'(32'hB0 + i)});
        rd_chk("ovf_status", 2'd0, 32'h0000_0427);
        chk("ovf_irq", {31'b0, irq}, 32'd1);
        wr(2'd3, 32'h3);
        rd_chk("ovf_clr", 2'd0, 32'h0000_0423);

        cpu_valid  = 1'b1;
        cpu_rdstrb = 1'b1;
        cpu_addr   = 2'd2;
        usb_report = 1'b1;
        usb_type   = 2'd3;
        hid_report = 64'h0000_00C3_0000_00D3;
        @(posedge clk);
        #1;
        usb_report = 1'b0;
        usb_type   = 2'd0;
        chk("coin_ready", {31'b0, cpu_ready}, 32'd1);
        chk("coin_hi", cpu_rdata, 32'h0000_00A0);
        cpu_valid  = 1'b0;
        cpu_rdstrb = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("coin_status", 2'd0, 32'h0000_0423);
        for (int i = 1; i < 4; i++) begin
            rd_chk("drain_lo", 2'd1, 32'(32'hB0 + i));
            rd_chk("drain_hi", 2'd2, 32'(32'hA0 + i));
        end
        rd_chk("last_status", 2'd0, 32'h0000_0131);
        rd_chk("last_lo", 2'd1, 32'h0000_00D3);
        rd_chk("last_hi", 2'd2, 32'h0000_00C3);
        rd_chk("drained", 2'd0, 32'h0000_0000);

        for (int i = 0; i < 3; i++)
            push(2'd1, 64'h11 + 64'(i));
        rd_chk("three_status", 2'd0, 32'h0000_0311);
        usb_conerr = 1'b1;
        usb_report = 1'b1;
        usb_type   = 2'd1;
        hid_report = 64'h99;
        @(posedge clk);
        #1;
        usb_report = 1'b0;
        usb_type   = 2'd0;
        rd_chk("cerr_status", 2'd0, 32'h0000_0008);
        chk("cerr_irq", {31'b0, irq}, 32'd1);
        push(2'd1, 64'h0000_0007_0000_0077);
        rd_chk("cerr_hold", 2'd0, 32'h0000_0119);
        wr(2'd3, 32'h3);
        rd_chk("cerr_clr", 2'd0, 32'h0000_0111);
        rd_chk("cerr_lo", 2'd1, 32'h0000_0077);
        wr(2'd3, 32'h5);
        rd_chk("flush", 2'd0, 32'h0000_0000);
        chk("flush_irq", {31'b0, irq}, 32'd0);
        rd_chk("empty_hi", 2'd2, 32'h0000_0000);
        rd_chk("empty_after", 2'd0, 32'h0000_0000);
        usb_conerr = 1'b0;

        push(2'd0, 64'h1234);
        rd_chk("type0", 2'd0, 32'h0000_0000);

        push(2'd1, 64'h0000_0001_0000_0055);
        push(2'd1, 64'h0000_0001_0000_0055);
        push(2'd1, 64'h0000_0001_0000_0056);
`ifdef HID_QUEUE_DEDUP_EN
        rd_chk("dedup", 2'd0, 32'h0000_0211);
`else
        rd_chk("dedup", 2'd0, 32'h0000_0311);
`endif

        cpu_valid  = 1'b1;
        cpu_wrstrb = 1'b1;
        cpu_addr   = 2'd3;
        cpu_wdata  = 32'h5;
        usb_report = 1'b1;
        usb_type   = 2'd2;
        hid_report = 64'hABCD;
        @(posedge clk);
        #1;
        usb_report = 1'b0;
        usb_type   = 2'd0;
        chk("fp_ready", {31'b0, cpu_ready}, 32'd1);
        cpu_valid  = 1'b0;
        cpu_wrstrb = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("flush_push", 2'd0, 32'h0000_0000);

        cpu_valid  = 1'b1;
        cpu_rdstrb = 1'b1;
        cpu_addr   = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, cpu_ready}, 32'd0);
        cpu_valid  = 1'b0;
        cpu_rdstrb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_chk("rst_mid_status", 2'd0, 32'h0000_0000);
        rd_chk("rst_mid_ctrl", 2'd3, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
